neuron_mac_sequencer: RTL

- Sequencer and multiplier stage that sits directly upstream of the 21-bit neuron accumulator.
- Accepts a stream of signed input/weight pairs for one neuron and drives the accumulator's init, load_en and data_in pins:
  - clears the accumulator,
  - loads one sign-extended product per accepted pair,
  - loads the neuron bias.
- Then reads the accumulator result back, applies shift/ReLU/saturation, and emits one 8-bit unsigned activation over a valid/ready handshake.

---
 rtl/neuron_mac_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : neuron_mac_sequencer
// Streams signed x*w products and a bias into the external neuron accumulator,
// then shifts / ReLU-clamps / saturates the sum into one 8-bit activation.
// Rev    : 1.0
// ============================================================================
module neuron_mac_sequencer #(
    parameter int N_INPUTS = 62,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 21,
    parameter int SHIFT    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    output logic              acc_init,
    output logic              acc_load_en,
    output logic [ACC_W-1:0]  acc_data,
    input  logic [ACC_W-1:0]  acc_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              busy
);

    localparam int                 c_CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(N_INPUTS - 1);
    localparam int                 c_PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_DRAIN  = 3'd3,
        S_BIAS   = 3'd4,
        S_SETTLE = 3'd5,
        S_OUT    = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [15:0]          r_bias;
    logic                 r_in_ready;
    logic                 r_acc_init;
    logic                 r_prod_vld;
    logic [ACC_W-1:0]     r_prod;
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic                 r_busy;

    logic signed [c_PROD_W-1:0] w_x_ext;
    logic signed [c_PROD_W-1:0] w_w_ext;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_shifted;
    logic [7:0]                 w_act;
    logic                       w_accept;

    // Operands are widened first so the low 2*DATA_W bits hold the exact signed product
    assign w_x_ext  = {{DATA_W{in_x[DATA_W-1]}}, in_x};
    assign w_w_ext  = {{DATA_W{in_w[DATA_W-1]}}, in_w};
    assign w_prod   = w_x_ext * w_w_ext;
    assign w_accept = in_valid && r_in_ready;

    assign w_shifted = $signed(acc_value) >>> SHIFT;
    assign w_act     = w_shifted[ACC_W-1]        ? 8'h00 :
                       (|w_shifted[ACC_W-2:8])   ? 8'hFF :
                                                   w_shifted[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bias      <= '0;
            r_in_ready  <= 1'b0;
            r_acc_init  <= 1'b0;
            r_prod_vld  <= 1'b0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bias     <= bias;
                        r_acc_init <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_acc_init <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_ACCUM;
                end
                S_ACCUM: begin
                    r_prod_vld <= w_accept;
                    if (w_accept) begin
                        r_prod <= {{(ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
                        r_cnt  <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last product is on the bus now; the bias follows directly
                    r_prod_vld <= 1'b1;
                    r_prod     <= {{(ACC_W-16){r_bias[15]}}, r_bias};
                    r_state    <= S_BIAS;
                end
                S_BIAS: begin
                    r_prod_vld <= 1'b0;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_out_data  <= w_act;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign acc_init    = r_acc_init;
    assign acc_load_en = r_prod_vld;
    assign acc_data    = r_prod;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign busy        = r_busy;

endmodule
`default_nettype wire
